// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid register slice.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH_DEF = 32;
  localparam int unsigned PIPE_WIDTH_MAX = 256;
  localparam logic [PIPE_WIDTH_MAX-1:0] PIPE_RESET_VAL_DEF = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // Entry count held in a given state.
  function automatic logic [1:0] pipe_occupancy(input pipe_state_e s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register: load enable, synchronous clear and async reset to RESET_VAL.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // Clear wins over load so a flush never lets new data slip in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= RESET_VAL;
    end else if (clr_i) begin
      data_q <= RESET_VAL;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register; SKID=1 adds a second entry so in_ready is a pure flop.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL_DEF),
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_xfer, out_xfer;
  logic             main_load, skid_load, main_sel_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  // Next-state and data-register load decisions.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    skid_load     = 1'b0;
    main_sel_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer && SKID) begin
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d       = ONE;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
    occ_d       = pipe_occupancy(state_d);
  end

  // in_ready_q stays 0 through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush),
    .load_i (main_load),
    .data_i (main_d),
    .data_o (main_q)
  );

  if (SKID) begin : g_skid
    pipe_data_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (flush),
      .load_i (skid_load),
      .data_i (in_data),
      .data_o (skid_q)
    );
    assign in_ready = in_ready_q;
  end else begin : g_noskid
    // Single entry: accept when empty or when the head leaves this cycle.
    assign skid_q   = RESET_VAL;
    assign in_ready = in_ready_q & (~out_valid_q | out_ready);
  end

  assign out_data  = main_q;
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: SKID=1 and SKID=0 instances against a bounded-FIFO reference model.
module tb_pipe_skid_reg;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 1 drives the SKID=1 instance, index 0 the SKID=0 instance.
  logic         iv   [2];
  logic         ordy [2];
  logic         fl   [2];
  logic [W-1:0] din  [2];
  logic         ir   [2];
  logic         ov   [2];
  logic [W-1:0] od   [2];
  logic [1:0]   oc   [2];

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] ent [2][2];
  int           cnt [2];
  int           pops [2];
  bit           live;

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_data(din[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .occupancy(oc[1])
  );

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_data(din[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .occupancy(oc[0])
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [W-1:0] x, input bit r, input bit f);
    iv[d] = v; din[d] = x; ordy[d] = r; fl[d] = f;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_valid[s%0d]", tag, d), W'(ov[d]), W'(1'b0));
      check($sformatf("%s_occ[s%0d]", tag, d), W'(oc[d]), W'(0));
      check($sformatf("%s_rdy[s%0d]", tag, d), W'(ir[d]), W'(1'b0));
      check($sformatf("%s_data[s%0d]", tag, d), od[d], RV);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit rdy [2];
    bit ix  [2];
    bit ox  [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!live)       rdy[d] = 1'b0;
      else if (d == 1) rdy[d] = (cnt[d] < 2);
      else             rdy[d] = (cnt[d] == 0) || ordy[d];
      check($sformatf("in_ready[s%0d]", d), W'(ir[d]), W'(rdy[d]));
      check($sformatf("out_valid[s%0d]", d), W'(ov[d]), W'(cnt[d] > 0));
      check($sformatf("occupancy[s%0d]", d), W'(oc[d]), W'(cnt[d]));
      if (cnt[d] > 0) check($sformatf("out_data[s%0d]", d), od[d], ent[d][0]);
      if (ov[d] && ordy[d]) pops[d]++;
      ix[d] = iv[d] && rdy[d];
      ox[d] = (cnt[d] > 0) && ordy[d];
    end
    @(posedge clk);
    live = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (fl[d]) begin
        cnt[d] = 0;
      end else begin
        if (ox[d]) begin
          ent[d][0] = ent[d][1];
          cnt[d]--;
        end
        if (ix[d]) begin
          ent[d][cnt[d]] = din[d];
          cnt[d]++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    live = 1'b0;
    for (int d = 0; d < 2; d++) begin cnt[d] = 0; pops[d] = 0; end
    #2;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) check($sformatf("post_rst_data[s%0d]", d), od[d], RV);

    // Fill the skid buffer with downstream stalled, then drain it.
    drive(1, 1'b1, 32'h11, 1'b0, 1'b0); cycle();
    drive(1, 1'b1, 32'h22, 1'b0, 1'b0); cycle();
    drive(1, 1'b0, '0, 1'b0, 1'b0);     cycle();
    drive(1, 1'b0, '0, 1'b1, 1'b0);     cycle(); cycle(); cycle();
    idle(); cycle();

    // Full-rate streaming through the SKID=1 instance.
    pops[1] = 0;
    for (int i = 1; i <= 100; i++) begin
      drive(1, 1'b1, W'(i), 1'b1, 1'b0);
      cycle();
    end
    drive(1, 1'b0, '0, 1'b1, 1'b0); cycle();
    check("stream_pops", W'(pops[1]), W'(100));
    idle(); cycle();

    // Flush while full; the entry offered alongside the flush must vanish.
    drive(1, 1'b1, 32'hAA, 1'b0, 1'b0); cycle();
    drive(1, 1'b1, 32'hBB, 1'b0, 1'b0); cycle();
    drive(1, 1'b1, 32'hCC, 1'b0, 1'b1); cycle();
    check("flush_data", od[1], RV);
    drive(1, 1'b0, '0, 1'b1, 1'b0); cycle(); cycle(); cycle();

    // SKID=0 pass-through: accept while the head leaves in the same cycle.
    drive(0, 1'b1, 32'h44, 1'b0, 1'b0); cycle();
    drive(0, 1'b1, 32'h55, 1'b1, 1'b0); cycle();
    drive(0, 1'b1, 32'h66, 1'b0, 1'b0); cycle();
    drive(0, 1'b0, '0, 1'b1, 1'b0);     cycle(); cycle();
    idle(); cycle();

    // Asynchronous reset pulse between edges with both instances holding data.
    drive(1, 1'b1, 32'h77, 1'b0, 1'b0); drive(0, 1'b1, 32'h78, 1'b0, 1'b0); cycle();
    drive(1, 1'b1, 32'h79, 1'b0, 1'b0); cycle();
    idle();
    #1 rst = 1'b0;
    #1 check_cleared("async_rst");
    #1 rst = 1'b1;
    for (int d = 0; d < 2; d++) cnt[d] = 0;
    live = 1'b0;
    @(posedge clk);
    live = 1'b1;
    @(negedge clk);
    cycle();

    // Randomised valid/ready/flush stress on both instances.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom % 4) != 0, $urandom,
              (i < 1500) ? (($urandom % 4) == 0) : (($urandom % 3) != 0),
              ($urandom % 40) == 0);
      end
      cycle();
    end
    idle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
